// File: rtl/branch_ctrl_pkg.sv
// Shared types for the branch/fetch-PC controller: FSM state encoding and defaults.
package branch_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SHADOW = 2'd1,
      ERR    = 2'd2
   } state_e;

   localparam int unsigned INSN_BYTES_DEF = 4;
   localparam int unsigned PC_W           = 32;

endpackage

// File: rtl/branch_ctrl_if.sv
// Pipeline-side signal bundle for branch_ctrl; master drives EX/fetch status, slave is the controller.
interface branch_ctrl_if;
   import branch_ctrl_pkg::*;

   logic            ex_valid;
   logic            ex_jump_en;
   logic [PC_W-1:0] ex_jump_target;
   logic            stall_in;
   logic            fetch_ready;
   logic [PC_W-1:0] pc_out;
   logic            pc_valid;
   logic            flush_if;
   logic            flush_id;
   logic            misalign_err;

   modport master (
      output ex_valid, ex_jump_en, ex_jump_target, stall_in, fetch_ready,
      input  pc_out, pc_valid, flush_if, flush_id, misalign_err
   );

   modport slave (
      input  ex_valid, ex_jump_en, ex_jump_target, stall_in, fetch_ready,
      output pc_out, pc_valid, flush_if, flush_id, misalign_err
   );
endinterface

// File: rtl/branch_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_cnt #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// Fetch-PC sequencer with taken-branch redirect, one-cycle shadow flush and sticky misalign trap.
// Define BRANCH_STATS_EN to add taken_cnt / shadow_cnt saturating statistics outputs.
//
// state  | meaning
// RUN    | normal sequential fetch, branches accepted
// SHADOW | first cycle after redirect; kill the wrong-path fetch, ignore branches
// ERR    | misaligned taken target seen; fetch halted until reset
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     INSN_BYTES = INSN_BYTES_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   branch_ctrl_if.slave     bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [PC_W-1:0]  taken_cnt,
   output logic [PC_W-1:0]  shadow_cnt
`endif
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic [PC_W-1:0] pc_inc;
   logic            take;
   logic            accept;
   logic            flush_if, flush_id, pc_valid;

   assign pc_inc = pc_q + PC_W'(INSN_BYTES);
   assign take   = bus.ex_valid && bus.ex_jump_en && !bus.stall_in;
   assign accept = (state_q == RUN) && take && (bus.ex_jump_target[1:0] == 2'b00);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      err_d    = err_q;
      flush_if = 1'b0;
      flush_id = 1'b0;
      pc_valid = 1'b1;
      case (state_q)
         RUN: begin
            if (!bus.stall_in) begin
               if (accept) begin
                  flush_if = 1'b1;
                  flush_id = 1'b1;
                  pc_d     = bus.ex_jump_target;
                  // Without a fetch handshake in T nothing wrong-path was issued, so no shadow.
                  state_d  = bus.fetch_ready ? SHADOW : RUN;
               end else if (take) begin
                  flush_if = 1'b1;
                  flush_id = 1'b1;
                  err_d    = 1'b1;
                  state_d  = ERR;
                  if (bus.fetch_ready) pc_d = pc_inc;
               end else if (bus.fetch_ready) begin
                  pc_d = pc_inc;
               end
            end
         end
         SHADOW: begin
            if (!bus.stall_in) begin
               flush_if = 1'b1;
               state_d  = RUN;
               if (bus.fetch_ready) pc_d = pc_inc;
            end
         end
         ERR: begin
            pc_valid = 1'b0;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign bus.pc_out       = pc_q;
   assign bus.pc_valid     = pc_valid;
   assign bus.flush_if     = flush_if;
   assign bus.flush_id     = flush_id;
   assign bus.misalign_err = err_q;

`ifdef BRANCH_STATS_EN
   sat_cnt #(.WIDTH(PC_W)) u_taken_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (accept),
      .cnt_o (taken_cnt)
   );

   sat_cnt #(.WIDTH(PC_W)) u_shadow_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (state_q == SHADOW),
      .cnt_o (shadow_cnt)
   );
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: the fetch PC after reset.
REQ-002 SHALL have parameter INSN_BYTES, default 4: the sequential PC increment.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port ex_valid, input, 1: the EX stage holds a valid instruction.
REQ-006 SHALL have port ex_jump_en, input, 1: the branch unit resolves taken.
REQ-007 SHALL have port ex_jump_target, input, 32: the branch unit target address.
REQ-008 SHALL have port stall_in, input, 1: the pipeline is stalled and EX is frozen.
REQ-009 SHALL have port fetch_ready, input, 1: the fetch unit consumes pc_out this cycle.
REQ-010 SHALL have port pc_out, output, 32: the fetch address presented to instruction memory.
REQ-011 SHALL have port pc_valid, output, 1: pc_out is a legal fetch request.
REQ-012 SHALL have port flush_if, output, 1: kill the IF/ID register content.
REQ-013 SHALL have port flush_id, output, 1: kill the ID/EX register content.
REQ-014 SHALL have port misalign_err, output, 1: sticky flag for a misaligned taken target.

Function
REQ-015 SHALL define "accept" as state==RUN && ex_valid && ex_jump_en && !stall_in, with ex_jump_target[1:0]==0.
REQ-016 SHALL implement states RUN, SHADOW and ERR in a registered FSM.
REQ-017 In RUN, when there is no accept, SHALL set pc_out <= pc_out+INSN_BYTES if fetch_ready, else hold pc_out; the add wraps modulo 2^32.
REQ-018 On accept in cycle T, SHALL drive flush_if=flush_id=1 combinationally in T and load pc_out <= ex_jump_target at T+1; the target overrides the increment.
REQ-019 On accept with fetch_ready=1 in T, SHALL enter SHADOW at T+1; with fetch_ready=0, SHALL stay in RUN.
REQ-020 In SHADOW, SHALL assert flush_if for exactly one cycle (killing the wrong-path fetch issued at T), ignore ex_jump_en, advance pc_out on fetch_ready, and return to RUN.
REQ-021 If ex_valid && ex_jump_en && !stall_in occurs in RUN with ex_jump_target[1:0]!=0, SHALL assert flush_if/flush_id that cycle, set misalign_err, and enter ERR.
REQ-022 In ERR, SHALL hold pc_valid=0, misalign_err=1 and pc_out frozen, and leave ERR only by reset.
REQ-023 SHALL drive pc_valid=1 in RUN and SHADOW.
REQ-024 SHALL hold all state and ignore ex_jump_en while stall_in=1; flush outputs stay low.
REQ-025 A taken branch held across stall cycles SHALL be accepted exactly once, in the first cycle stall_in is low.

Reset
REQ-026 When rstn=0 at a clock edge, in any state including SHADOW and ERR, SHALL set state=RUN, pc_out=RESET_PC and misalign_err=0.
REQ-027 Out of reset, SHALL drive pc_valid=1, flush_if=0 and flush_id=0.

Configuration
REQ-028 With macro BRANCH_STATS_EN defined, SHALL add 32-bit outputs taken_cnt (increments on each accept) and shadow_cnt (increments on each SHADOW cycle).
REQ-029 Both counters SHALL be reset to 0 and saturate at 32'hFFFF_FFFF.
REQ-030 Without BRANCH_STATS_EN, SHALL omit both ports and all counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL place the state enum typedef (RUN/SHADOW/ERR) and the INSN_BYTES default in package branch_ctrl_pkg.
REQ-032 SHALL implement the stats counters as two instances of sub-module sat_cnt (32-bit saturating counter with synchronous active-low reset and an increment enable).

Verification
REQ-033 Reset then fetch_ready=1 for 3 cycles -> pc_out sequence 0x0, 0x4, 0x8, 0xC; flush outputs stay 0.
REQ-034 Accept with target 0x100 and fetch_ready=1 -> flush_if=flush_id=1 in T; pc_out=0x100 at T+1; flush_if=1 only at T+1 (SHADOW); RUN at T+2.
REQ-035 Accept with target 0x200 and fetch_ready=0 -> flushes in T; pc_out=0x200 at T+1; no SHADOW cycle.
REQ-036 Taken branch held with stall_in=1 for 3 cycles, then released -> no flush during the stall; exactly one accept; taken_cnt=1 (with BRANCH_STATS_EN).
REQ-037 Taken target 0x102 -> misalign_err=1 and pc_valid=0 from the next cycle; both persist; rstn=0 for one edge restores pc_out=RESET_PC and misalign_err=0.
REQ-038 pc_out=0xFFFF_FFFC with fetch_ready=1 -> pc_out wraps to 0x0; ex_jump_en asserted during SHADOW -> ignored.
